inv_byte_sub_iter: RTL

Iterative AES InvSubBytes engine: accepts a 128-bit state over a valid/ready handshake, replaces every byte with its FIPS-197 inverse S-box value over 16/BPC cycles, and returns the result over a second valid/ready handshake. It sits in the decryption datapath as the inverse counterpart of the forward SubBytes stage. It trades the 16 parallel lookups of the forward stage for BPC shared lookups per cycle. Applying it to the output of the forward SubBytes stage returns the original state.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/inv_sbox.sv | 19 +
 rtl/inv_byte_sub_iter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : AES tables and shared types for the SubBytes / InvSubBytes
//               stages. Holds the inverse S-box and the iterative engine's
//               FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Engine control states. Encoding is explicit so that waveforms and
    // netlists keep stable values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIPS-197 inverse S-box, indexed by the substituted byte value.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox
// Description : Combinational 8-bit AES inverse S-box lookup.
// Ports       : i_byte  in  8  byte to substitute
//               o_byte  out 8  inverse S-box value of i_byte
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = INV_SBOX[i_byte];

endmodule : inv_sbox
`default_nettype wire

// File: rtl/inv_byte_sub_iter.sv
`default_nettype none
// ============================================================================
// Module      : inv_byte_sub_iter
// Description : Iterative AES InvSubBytes engine. Accepts a 128-bit state,
//               substitutes BPC bytes per cycle (MSB byte first) through BPC
//               shared inverse S-boxes, then presents the result until the
//               consumer accepts it.
// Ports       : clk        in   1    clock, rising edge
//               rst        in   1    asynchronous active-high reset
//               in_valid   in   1    in_data is valid
//               in_ready   out  1    engine can accept a block (IDLE only)
//               in_data    in   128  state; byte 0 = [127:120]
//               out_valid  out  1    out_data holds a completed block
//               out_ready  in   1    consumer accepts out_data
//               out_data   out  128  inverse-substituted state
//               busy       out  1    engine is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module inv_byte_sub_iter
    import aes_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int c_n_chunks = 16 / BPC;
    localparam int c_cnt_w    = (c_n_chunks > 1) ? $clog2(c_n_chunks) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_chunks - 1);

    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
        $error("inv_byte_sub_iter: BPC must be 1, 2, 4, 8 or 16");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    // Element [15] is byte 0 (the most significant byte of in_data).
    logic [15:0][7:0]     r_work;
    logic [15:0][7:0]     w_work_sub;
    logic [3:0]           w_base;
    logic [7:0]           w_sb_in  [BPC];
    logic [7:0]           w_sb_out [BPC];

    // First byte number of the chunk handled this cycle.
    assign w_base = 4'(int'(r_cnt) * BPC);

    // Chunk mux: byte number (w_base + j) lives at element 15 - (w_base + j).
    always_comb begin
        for (int j = 0; j < BPC; j++) begin
            w_sb_in[j] = r_work[4'(15 - int'(w_base) - j)];
        end
    end

    for (genvar g = 0; g < BPC; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .i_byte (w_sb_in[g]),
            .o_byte (w_sb_out[g])
        );
    end

    always_comb begin
        w_work_sub = r_work;
        for (int j = 0; j < BPC; j++) begin
            w_work_sub[4'(15 - int'(w_base) - j)] = w_sb_out[j];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_state_nxt = SUB;
            SUB:     if (r_cnt == c_last)  w_state_nxt = DONE;
            DONE:    if (out_ready)        w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_cnt  <= '0;
                    end
                end
                SUB: begin
                    r_work <= w_work_sub;
                    // Hold on the last chunk so the counter never wraps.
                    if (r_cnt != c_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    // Gated so partially substituted blocks never reach the output.
    assign out_data  = (r_state == DONE) ? 128'(r_work) : 128'h0;

endmodule : inv_byte_sub_iter
`default_nettype wire
